// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: MSB-first square-and-multiply sequencer driving one mon_prod (OPXX/OPXM/OPX1).
// Optional per-op timeout enabled by defining MP_TIMEOUT_EN.
module mod_exp_ctrl #(
  parameter int BITLEN  = 256,
  parameter int EBITS   = 256,
  parameter int OPCNT_W = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [EBITS-1:0]   E,
  input  logic [BITLEN-1:0]  M_in,
  input  logic [9:0]         count_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [OPCNT_W-1:0] op_cnt,
  output logic               mp_start,
  output logic [1:0]         mp_op_code,
  output logic [BITLEN-1:0]  mp_M,
  output logic [9:0]         mp_count,
  input  logic               mp_stop
);

  localparam int IW = (EBITS > 1) ? $clog2(EBITS) : 1;
  localparam logic [1:0] OPXX = 2'd0;
  localparam logic [1:0] OPXM = 2'd1;
  localparam logic [1:0] OPX1 = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_SCAN, S_SQ_ISSUE, S_SQ_WAIT, S_MUL_ISSUE, S_MUL_WAIT,
    S_NEXT, S_FIN_ISSUE, S_FIN_WAIT, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [EBITS-1:0]    r_e;
  logic [IW-1:0]       r_idx;
  logic [BITLEN-1:0]   r_m;
  logic [9:0]          r_count;
  logic [OPCNT_W-1:0]  r_op_cnt;
  logic                r_stop_q;

  logic w_accept;
  logic w_cmpl;
  logic w_bit;
  logic w_idx_zero;
  logic w_issue;
  logic w_wait;
  logic w_tmo_hit;

  // Only a fresh rising edge of stop counts; a level left over from the previous op does not.
  assign w_cmpl     = mp_stop & ~r_stop_q;
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_bit      = r_e[r_idx];
  assign w_idx_zero = (r_idx == '0);
  assign w_issue    = (r_state == S_SQ_ISSUE) || (r_state == S_MUL_ISSUE) ||
                      (r_state == S_FIN_ISSUE);
  assign w_wait     = (r_state == S_SQ_WAIT) || (r_state == S_MUL_WAIT) ||
                      (r_state == S_FIN_WAIT);

`ifdef MP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;

  // r_tmo = cycles elapsed since mp_start, the issue cycle being the first.
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));
  assign err       = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_issue)
        r_tmo <= TMO_W'(1);
      else if (w_wait && (r_tmo != '1))
        r_tmo <= r_tmo + 1'b1;
      if (w_accept)
        r_err <= 1'b0;
      else if (w_wait && !w_cmpl && w_tmo_hit)
        r_err <= 1'b1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_next = S_SCAN;
      S_SCAN: begin
        if (w_bit)           w_next = S_SQ_ISSUE;
        else if (w_idx_zero) w_next = S_FIN_ISSUE;
      end
      S_SQ_ISSUE:  w_next = S_SQ_WAIT;
      S_SQ_WAIT: begin
        if (w_cmpl)         w_next = w_bit ? S_MUL_ISSUE : S_NEXT;
        else if (w_tmo_hit) w_next = S_DONE;
      end
      S_MUL_ISSUE: w_next = S_MUL_WAIT;
      S_MUL_WAIT: begin
        if (w_cmpl)         w_next = S_NEXT;
        else if (w_tmo_hit) w_next = S_DONE;
      end
      S_NEXT:      w_next = w_idx_zero ? S_FIN_ISSUE : S_SQ_ISSUE;
      S_FIN_ISSUE: w_next = S_FIN_WAIT;
      S_FIN_WAIT:  if (w_cmpl || w_tmo_hit) w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    done       = (r_state == S_DONE);
    mp_start   = w_issue;
    mp_op_code = OPXX;
    case (r_state)
      S_MUL_ISSUE, S_MUL_WAIT: mp_op_code = OPXM;
      S_FIN_ISSUE, S_FIN_WAIT: mp_op_code = OPX1;
      default:                 mp_op_code = OPXX;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e      <= '0;
      r_idx    <= '0;
      r_m      <= '0;
      r_count  <= '0;
      r_op_cnt <= '0;
      r_stop_q <= 1'b0;
    end else begin
      r_stop_q <= mp_stop;
      if (w_accept) begin
        r_e      <= E;
        r_m      <= M_in;
        r_count  <= count_in;
        r_op_cnt <= '0;
        r_idx    <= IW'(EBITS - 1);
      end else begin
        if ((r_state == S_SCAN) && !w_bit && !w_idx_zero)
          r_idx <= r_idx - 1'b1;
        if ((r_state == S_NEXT) && !w_idx_zero)
          r_idx <= r_idx - 1'b1;
        if (w_issue && (r_op_cnt != '1))
          r_op_cnt <= r_op_cnt + 1'b1;
      end
    end
  end

  assign op_cnt   = r_op_cnt;
  assign mp_M     = r_m;
  assign mp_count = r_count;

endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
- Sequencer that drives one mon_prod instance through a Montgomery modular exponentiation, using MSB-first square-and-multiply over exponent E.
- Issues OPXX (square), OPXM (multiply by the pre-loaded base) and a closing OPX1 (convert out of the Montgomery domain).
- Sits between the host/top-level RSA FSM and mon_prod; owns mon_prod's start/op_code/M/mp_count inputs.
- Operands already reside in bram: X initialised to R mod M, base pre-transformed. This block never touches bram.

Parameters:
- BITLEN, 256, modulus width.
- EBITS, 256, exponent width.
- OPCNT_W, 16, width of the issued-operation counter.
- TIMEOUT, 4096, max cycles allowed per mon_prod op (only used with MP_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  host request; sampled in IDLE only.
- E  in  EBITS  exponent; latched on accepted start.
- M_in  in  BITLEN  modulus; latched on accepted start.
- count_in  in  10  mon_prod iteration count; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the final OPX1 completes.
- err  out  1  timeout flag (MP_TIMEOUT_EN only; otherwise tied 0).
- op_cnt  out  OPCNT_W  number of mon_prod ops issued in the current/last job.
- mp_start  out  1  one-cycle start pulse to mon_prod.
- mp_op_code  out  2  OPXX=0, OPXM=1, OPX1=2; held stable from issue until completion.
- mp_M  out  BITLEN  latched modulus.
- mp_count  out  10  latched count.
- mp_stop  in  1  mon_prod stop; completion is its rising edge.

Behaviour:
- Reset (async, any state): state=IDLE. busy, done, err and mp_start are 0. mp_op_code=0, op_cnt=0. mp_M, mp_count and the E register are 0. stop_q (registered mp_stop) is 0.
- Completion is defined as mp_stop & ~stop_q. A stop level already high when an op is issued is not a completion.
- States:
  - IDLE: on start=1, latch E/M_in/count_in, clear op_cnt and err, set bit index i=EBITS-1, go to SCAN. Otherwise stay in IDLE.
  - SCAN: one bit per cycle.
    - If E[i]=1, go to SQ_ISSUE.
    - Else if i=0 (E==0), go to FIN_ISSUE.
    - Else decrement i.
    - Leading zeros are skipped, because squaring the Montgomery "1" is the identity.
  - SQ_ISSUE: mp_op_code=OPXX, mp_start=1 for exactly 1 cycle, op_cnt++. Then go to SQ_WAIT.
  - SQ_WAIT: on completion, go to MUL_ISSUE if E[i]=1, else to NEXT.
  - MUL_ISSUE: OPXM, 1-cycle pulse, op_cnt++. Then go to MUL_WAIT.
  - MUL_WAIT: on completion, go to NEXT.
  - NEXT: if i=0 go to FIN_ISSUE, else i-- and go to SQ_ISSUE.
  - FIN_ISSUE: OPX1, 1-cycle pulse, op_cnt++. Then go to FIN_WAIT.
  - FIN_WAIT: on completion, go to DONE.
  - DONE: done=1 for 1 cycle, busy=0, go to IDLE.
- Latency:
  - start to first mp_start = 2 + (number of leading zeros) cycles.
  - Each op completion to the next mp_start = 1 cycle (2 via NEXT).
- Op counts:
  - Total ops = (bit-length of E) + popcount(E) + 1.
  - E=0 gives 1 op (OPX1 only).
- start while busy: ignored; no re-latch.
- mp_op_code, mp_M and mp_count are constant throughout each op's WAIT state.
- op_cnt saturates at all-ones and holds its value after done until the next accepted start.
- Reset mid-operation: abandon the job immediately; no done pulse. The mon_prod result is disregarded.

Optional Feature:
- Macro: MP_TIMEOUT_EN.
- Defined:
  - A per-op cycle counter is cleared on each mp_start and increments in every WAIT state.
  - If it reaches TIMEOUT before completion, set err=1, go to DONE (done pulses, busy drops) and skip the remaining ops.
  - err holds until the next accepted start or reset.
- Not defined: no counter; WAIT states wait indefinitely; err is constant 0.

Test Plan:
- Bench model: mon_prod stub asserts stop 12 cycles after mp_start and drops it on the next mp_start.
- E=0, M_in=589, count_in=10 -> single op OPX1; done once; op_cnt=1; busy low after done.
- E=1 -> op sequence OPXX, OPXM, OPX1; op_cnt=3; first mp_start 2+255 cycles after start (EBITS=256).
- E=5 (101b) -> OPXX, OPXM, OPXX, OPXX, OPXM, OPX1; op_cnt=6; mp_M=589 and mp_count=10 stable throughout.
- Extra start pulses during busy with E=3, then a changed E input -> ignored; sequence XX, XM, XX, XM, X1 unchanged; op_cnt=5.
- rst asserted during the second WAIT of E=5 -> all outputs at reset values on the same edge; no done pulse. A fresh start with E=1 then completes normally with op_cnt=3.
- MP_TIMEOUT_EN, TIMEOUT=20, stub never stops -> err=1 and done pulse exactly 20 cycles after the first mp_start; op_cnt=1.
